// File: rtl/cmerge6_cache_sync.sv
`default_nettype none
// ============================================================================
//  Module   : cmerge6_cache_sync
//  Brief    : Clocked 6-to-1 round-robin merge. Per-channel drive pulses are
//             captured with their payloads. One channel at a time is forwarded
//             downstream as a drive/data pulse. The downstream free pulse is
//             then returned to the granted channel.
//  Revision : 1.0 - initial release
// ============================================================================
module cmerge6_cache_sync #(
    parameter  int DW  = 32,
    parameter  int NCH = 6,
    localparam int SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    i_drive,
    input  logic [NCH*DW-1:0] i_data,
    output logic [NCH-1:0]    o_free,
    output logic              o_driveNext,
    output logic              o_fire,
    output logic [SW-1:0]     o_sel,
    output logic [DW-1:0]     o_data,
    input  logic              i_freeNext,
    output logic              o_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [NCH-1:0]    r_pending;
    logic [DW-1:0]     r_dreg [NCH];
    logic [SW-1:0]     r_ptr;
    logic [SW-1:0]     r_sel;
    logic [DW-1:0]     r_data;
    logic              r_drive_next;
    logic              r_fire;
    logic [NCH-1:0]    r_free;
    logic              r_err;

    logic [NCH-1:0]    w_set;
    logic [NCH-1:0]    w_drive_err;
    logic [NCH-1:0]    w_clr;
    logic [NCH-1:0]    w_pending_next;
    logic              w_found;
    logic [SW-1:0]     w_grant;
    logic [SW-1:0]     w_idx;
    logic              w_grant_go;
    logic              w_done;
    logic              w_err_free_idle;

    // Modular add that does not rely on NCH being a power of two.
    function automatic logic [SW-1:0] f_wrap_add(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) s = s - NCH;
        return SW'(s);
    endfunction

    // A new pulse is only accepted on an idle channel; a repeat pulse is a protocol error and is dropped.
    assign w_set       = i_drive & ~r_pending;
    assign w_drive_err = i_drive &  r_pending;

    // Round-robin search over pending channels, starting at the rotating pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = f_wrap_add(r_ptr, i);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic and transaction strobes.
    always_comb begin
        w_state_next    = r_state;
        w_grant_go      = 1'b0;
        w_done          = 1'b0;
        w_err_free_idle = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_BUSY;
                    w_grant_go   = 1'b1;
                end
                if (i_freeNext) w_err_free_idle = 1'b1;
            end
            S_BUSY: begin
                if (i_freeNext) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Completion clears the granted channel; clear always takes priority over a new set.
    always_comb begin
        w_clr = '0;
        if (w_done) w_clr[r_sel] = 1'b1;
        w_pending_next = (r_pending | w_set) & ~w_clr;
    end

    // Per-channel payload capture, taken only when the pulse is accepted.
    for (genvar k = 0; k < NCH; k++) begin : g_chan
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)         r_dreg[k] <= '0;
            else if (w_set[k]) r_dreg[k] <= i_data[k*DW +: DW];
        end
    end

    // Grant/complete datapath, pulse outputs and sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending    <= '0;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_data       <= '0;
            r_drive_next <= 1'b0;
            r_fire       <= 1'b0;
            r_free       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_drive_next <= w_grant_go;
            r_fire       <= w_grant_go;
            r_free       <= w_clr;
            if (w_grant_go) begin
                r_sel  <= w_grant;
                r_data <= r_dreg[w_grant];
            end
            if (w_done) r_ptr <= f_wrap_add(r_sel, 1);
            if ((|w_drive_err) || w_err_free_idle) r_err <= 1'b1;
        end
    end

    assign o_free      = r_free;
    assign o_driveNext = r_drive_next;
    assign o_fire      = r_fire;
    assign o_sel       = r_sel;
    assign o_data      = r_data;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmerge6_cache_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmerge6_cache_sync
//  Brief    : Directed self-checking bench for cmerge6_cache_sync.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmerge6_cache_sync;

    localparam int DW  = 32;
    localparam int NCH = 6;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH-1:0]    i_drive;
    logic [NCH*DW-1:0] i_data;
    logic [NCH-1:0]    o_free;
    logic              o_driveNext;
    logic              o_fire;
    logic [2:0]        o_sel;
    logic [DW-1:0]     o_data;
    logic              i_freeNext;
    logic              o_err;

    int n_vec = 0;
    int n_err = 0;

    cmerge6_cache_sync #(.DW(DW), .NCH(NCH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_fire      (o_fire),
        .o_sel       (o_sel),
        .o_data      (o_data),
        .i_freeNext  (i_freeNext),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Bounded wait for the next grant, then check its contents.
    task automatic wait_grant(input string tag, input int exp_sel, input logic [31:0] exp_data);
        for (int n = 0; n < 20 && !o_driveNext; n++) tick();
        chk({tag, "_drv"},  64'(o_driveNext), 64'd1);
        chk({tag, "_fire"}, 64'(o_fire),      64'd1);
        chk({tag, "_sel"},  64'(o_sel),       64'(exp_sel));
        chk({tag, "_data"}, 64'(o_data),      64'(exp_data));
    endtask

    // Downstream completion one cycle after the grant, checking the returned free.
    task automatic complete(input string tag, input int sel);
        tick();
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
        chk({tag, "_free"}, 64'(o_free), 64'd1 << sel);
    endtask

    initial begin
        // 1: reset held with activity on the inputs
        rstn       = 1'b0;
        i_drive    = '1;
        i_data     = '1;
        i_freeNext = 1'b1;
        repeat (3) tick();
        chk("rst_free", 64'(o_free),      64'd0);
        chk("rst_drv",  64'(o_driveNext), 64'd0);
        chk("rst_fire", 64'(o_fire),      64'd0);
        chk("rst_sel",  64'(o_sel),       64'd0);
        chk("rst_data", 64'(o_data),      64'd0);
        chk("rst_err",  64'(o_err),       64'd0);
        i_drive    = '0;
        i_freeNext = 1'b0;
        i_data     = '0;
        rstn       = 1'b1;
        tick();
        chk("rel_err", 64'(o_err), 64'd0);
        chk("rel_drv", 64'(o_driveNext), 64'd0);
        tick();
        chk("rel_free", 64'(o_free), 64'd0);

        // 2: single transaction with exact latencies
        i_data[2*DW +: DW] = 32'hA5;
        i_drive = 6'b000100;
        tick();
        i_drive = '0;
        chk("s_c2_drv", 64'(o_driveNext), 64'd0);
        tick();
        chk("s_c3_drv",  64'(o_driveNext), 64'd1);
        chk("s_c3_fire", 64'(o_fire),      64'd1);
        chk("s_c3_sel",  64'(o_sel),       64'd2);
        chk("s_c3_data", 64'(o_data),      64'hA5);
        tick();
        chk("s_c4_drv", 64'(o_driveNext), 64'd0);
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
        chk("s_c5_free", 64'(o_free), 64'b000100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s_quiet_free", 64'(o_free),      64'd0);
            chk("s_quiet_drv",  64'(o_driveNext), 64'd0);
        end
        chk("s_sel_held", 64'(o_sel), 64'd2);
        chk("s_err", 64'(o_err), 64'd0);

        // 3: all six channels at once, round-robin from pointer 0
        do_reset();
        for (int k = 0; k < NCH; k++) i_data[k*DW +: DW] = 32'(k + 1);
        i_drive = '1;
        tick();
        i_drive = '0;
        for (int s = 0; s < NCH; s++) begin
            wait_grant("all", s, 32'(s + 1));
            complete("all", s);
        end
        chk("all_err", 64'(o_err), 64'd0);

        // 4: fairness between two channels that re-drive right after free
        i_data[1*DW +: DW] = 32'h101;
        i_data[4*DW +: DW] = 32'h104;
        i_drive = 6'b010010;
        tick();
        i_drive = '0;
        for (int g = 0; g < 10; g++) begin
            int exp_ch;
            exp_ch = (g % 2 == 0) ? 1 : 4;
            wait_grant("rr", exp_ch, 32'h100 + 32'(exp_ch));
            complete("rr", exp_ch);
            i_drive[exp_ch] = 1'b1;
            tick();
            i_drive = '0;
        end
        chk("rr_err", 64'(o_err), 64'd0);

        // 5: protocol errors
        do_reset();
        i_data[3*DW +: DW] = 32'h33;
        i_drive = 6'b001000;
        tick();
        i_data[3*DW +: DW] = 32'h99;
        tick();
        i_drive = '0;
        chk("e_err_set", 64'(o_err),       64'd1);
        chk("e_drv",     64'(o_driveNext), 64'd1);
        chk("e_sel",     64'(o_sel),       64'd3);
        chk("e_data",    64'(o_data),      64'h33);
        complete("e", 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("e_no_regrant", 64'(o_driveNext), 64'd0);
        end
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
        chk("e_idle_free", 64'(o_free), 64'd0);
        chk("e_err_stick", 64'(o_err),  64'd1);
        tick();
        chk("e_idle_free2", 64'(o_free), 64'd0);

        // 6: asynchronous reset in the middle of a transaction
        do_reset();
        chk("a_err_clr", 64'(o_err), 64'd0);
        i_data[5*DW +: DW] = 32'h55;
        i_drive = 6'b100000;
        tick();
        i_drive = '0;
        tick();
        chk("a_drv", 64'(o_driveNext), 64'd1);
        chk("a_sel", 64'(o_sel),       64'd5);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("a_sel0",  64'(o_sel),       64'd0);
        chk("a_data0", 64'(o_data),      64'd0);
        chk("a_drv0",  64'(o_driveNext), 64'd0);
        chk("a_free0", 64'(o_free),      64'd0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_no_free", 64'(o_free), 64'd0);
        end
        i_data[0*DW +: DW] = 32'h77;
        i_drive = 6'b000001;
        tick();
        i_drive = '0;
        chk("a_c2_drv", 64'(o_driveNext), 64'd0);
        tick();
        chk("a_c3_drv",  64'(o_driveNext), 64'd1);
        chk("a_c3_sel",  64'(o_sel),       64'd0);
        chk("a_c3_data", 64'(o_data),      64'h77);
        chk("a_c3_err",  64'(o_err),       64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
